// File: rtl/overworld_pkg.sv
// Shared overworld types: facing direction, movement FSM states and keyboard
// keycodes. Used by the motion controller and the colour mapper's animation FSM.
package overworld_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } Dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        MOVE = 2'd3
    } Motion_State;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;

    typedef struct packed {
        logic valid;
        Dir_t dir;
    } key_dir_t;

    // Unrecognised keycodes come back with valid=0; dir is then don't-care.
    function automatic key_dir_t decode_key(input logic [7:0] code);
        key_dir_t r;
        r.valid = 1'b1;
        r.dir   = DIR_DOWN;
        case (code)
            KEY_W:   r.dir = DIR_UP;
            KEY_D:   r.dir = DIR_RIGHT;
            KEY_S:   r.dir = DIR_DOWN;
            KEY_A:   r.dir = DIR_LEFT;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// Brings the VGA vertical sync into the clock domain with two flops and emits
// a one-cycle pulse on each rising edge: the frame tick.
module vs_edge_detect (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_vs,
    output logic o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_vs;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_tick = r_sync2 & ~r_prev;

endmodule

// File: rtl/player_motion_ctrl.sv
// Tile-by-tile player movement: samples the key once per frame, checks the
// target tile in the collision RAM, then scrolls the camera over several frames.
module player_motion_ctrl
    import overworld_pkg::*;
#(
    parameter int TILE_PX     = 16,
    parameter int STEP_PX     = 2,
    parameter int MAP_W_TILES = 40,
    parameter int MAP_H_TILES = 30,
    parameter int START_X     = 20,
    parameter int START_Y     = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        VS,
    input  logic [7:0]  keycode,
    input  logic        coll_rd_data,
    output logic        coll_rd_en,
    output logic [12:0] coll_addr,
    output logic        Character_Moving,
    output logic [1:0]  Direction,
    output logic [10:0] topleftX,
    output logic [10:0] topleftY,
    output logic [6:0]  tile_x,
    output logic [6:0]  tile_y
);

    localparam int STEPS  = TILE_PX / STEP_PX;
    localparam int STEP_W = $clog2(STEPS + 1);

    localparam logic signed [7:0] MAP_W_S = 8'(MAP_W_TILES);
    localparam logic signed [7:0] MAP_H_S = 8'(MAP_H_TILES);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic [10:0]       STEP_D    = 11'(STEP_PX);

    logic w_tick;

    vs_edge_detect u_vs_edge (
        .i_clk  (Clk),
        .i_srst (Reset),
        .i_vs   (VS),
        .o_tick (w_tick)
    );

    Motion_State       r_state, r_state_next;
    Dir_t              r_dir, r_dir_next;
    logic [6:0]        r_tile_x, r_tile_x_next;
    logic [6:0]        r_tile_y, r_tile_y_next;
    logic [6:0]        r_tgt_x, r_tgt_x_next;
    logic [6:0]        r_tgt_y, r_tgt_y_next;
    logic [10:0]       r_top_x, r_top_x_next;
    logic [10:0]       r_top_y, r_top_y_next;
    logic [STEP_W-1:0] r_step, r_step_next;
    logic              r_moving, r_moving_next;
    logic              r_rd_en, r_rd_en_next;
    logic [12:0]       r_addr, r_addr_next;

    key_dir_t          w_key;
    logic signed [7:0] w_cur_x;
    logic signed [7:0] w_cur_y;
    logic signed [7:0] w_nx;
    logic signed [7:0] w_ny;
    logic              w_on_map;
    logic [12:0]       w_tgt_addr;
    logic              w_last_step;

    // Candidate target for the key being pressed right now, signed so that
    // stepping off row/column 0 shows up as a negative coordinate.
    always_comb begin
        w_key   = decode_key(keycode);
        w_cur_x = $signed({1'b0, r_tile_x});
        w_cur_y = $signed({1'b0, r_tile_y});
        w_nx    = w_cur_x;
        w_ny    = w_cur_y;
        case (w_key.dir)
            DIR_UP:    w_ny = w_cur_y - 8'sd1;
            DIR_RIGHT: w_nx = w_cur_x + 8'sd1;
            DIR_DOWN:  w_ny = w_cur_y + 8'sd1;
            default:   w_nx = w_cur_x - 8'sd1;
        endcase
    end

    assign w_on_map   = (w_nx >= 8'sd0) && (w_nx < MAP_W_S) &&
                        (w_ny >= 8'sd0) && (w_ny < MAP_H_S);
    assign w_tgt_addr = 13'(w_ny[6:0]) * 13'(MAP_W_TILES) + 13'(w_nx[6:0]);
    assign w_last_step = (r_step == LAST_STEP);

    always_comb begin
        r_state_next  = r_state;
        r_dir_next    = r_dir;
        r_tile_x_next = r_tile_x;
        r_tile_y_next = r_tile_y;
        r_tgt_x_next  = r_tgt_x;
        r_tgt_y_next  = r_tgt_y;
        r_top_x_next  = r_top_x;
        r_top_y_next  = r_top_y;
        r_step_next   = r_step;
        r_moving_next = r_moving;
        r_rd_en_next  = 1'b0;
        r_addr_next   = r_addr;

        case (r_state)
            IDLE: begin
                // The player turns to face the key even if the move is refused.
                if (w_tick && w_key.valid) begin
                    r_dir_next = w_key.dir;
                    if (w_on_map) begin
                        r_tgt_x_next = w_nx[6:0];
                        r_tgt_y_next = w_ny[6:0];
                        r_addr_next  = w_tgt_addr;
                        r_rd_en_next = 1'b1;
                        r_state_next = REQ;
                    end
                end
            end
            REQ: begin
                r_state_next = WAIT;
            end
            WAIT: begin
                if (coll_rd_data) begin
                    r_state_next = IDLE;
                end else begin
                    r_moving_next = 1'b1;
                    r_step_next   = '0;
                    r_state_next  = MOVE;
                end
            end
            MOVE: begin
                if (w_tick) begin
                    r_step_next = r_step + STEP_W'(1);
                    case (r_dir)
                        DIR_UP:    r_top_y_next = r_top_y - STEP_D;
                        DIR_RIGHT: r_top_x_next = r_top_x + STEP_D;
                        DIR_DOWN:  r_top_y_next = r_top_y + STEP_D;
                        default:   r_top_x_next = r_top_x - STEP_D;
                    endcase
                    // Snap the camera to the tile grid so rounding can never drift.
                    if (w_last_step) begin
                        r_tile_x_next = r_tgt_x;
                        r_tile_y_next = r_tgt_y;
                        r_top_x_next  = 11'(r_tgt_x) * 11'(TILE_PX);
                        r_top_y_next  = 11'(r_tgt_y) * 11'(TILE_PX);
                        r_moving_next = 1'b0;
                        r_state_next  = IDLE;
                    end
                end
            end
            default: r_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_dir    <= DIR_DOWN;
            r_tile_x <= 7'(START_X);
            r_tile_y <= 7'(START_Y);
            r_tgt_x  <= 7'(START_X);
            r_tgt_y  <= 7'(START_Y);
            r_top_x  <= 11'(START_X * TILE_PX);
            r_top_y  <= 11'(START_Y * TILE_PX);
            r_step   <= '0;
            r_moving <= 1'b0;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_state  <= r_state_next;
            r_dir    <= r_dir_next;
            r_tile_x <= r_tile_x_next;
            r_tile_y <= r_tile_y_next;
            r_tgt_x  <= r_tgt_x_next;
            r_tgt_y  <= r_tgt_y_next;
            r_top_x  <= r_top_x_next;
            r_top_y  <= r_top_y_next;
            r_step   <= r_step_next;
            r_moving <= r_moving_next;
            r_rd_en  <= r_rd_en_next;
            r_addr   <= r_addr_next;
        end
    end

    // A frame is far longer than the 2-cycle RAM lookup, so a tick here means
    // VS is being driven far faster than any real video timing.
    a_no_tick_in_lookup: assert property (@(posedge Clk) disable iff (Reset)
        !(w_tick && (r_state == REQ || r_state == WAIT)));

    assign coll_rd_en       = r_rd_en;
    assign coll_addr        = r_addr;
    assign Character_Moving = r_moving;
    assign Direction        = r_dir;
    assign topleftX         = r_top_x;
    assign topleftY         = r_top_y;
    assign tile_x           = r_tile_x;
    assign tile_y           = r_tile_y;

endmodule
